// File: rtl/request_register_bank_pkg.sv
// Shared constants and helpers for the request holding stage and its arbiter.
package request_register_bank_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_DEPTH  = 2;
  localparam int DEF_NUM_CH = 4;

  // Ceiling log2: smallest n with 2**n >= v (clog2(1) == 0).
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x * 2;
      r++;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_SWAP = 2'd3
  } fifo_op_e;

endpackage

// File: rtl/request_register_bank_req_fifo.sv
// Single-channel request FIFO: circular buffer of DEPTH entries with a
// load/ack handshake, registered occupancy and a sticky overflow flag.
module req_fifo
  import request_register_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CW   = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             ack,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             ovf
);

  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_occ;
  logic             r_ovf;

  logic     w_empty;
  logic     w_full;
  logic     w_push;
  logic     w_pop;
  logic     w_drop;
  fifo_op_e w_op;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_empty = (r_occ == '0);
    w_full  = (r_occ == CW'(DEPTH));
    // A full channel still accepts a load when the head is released this cycle.
    w_push  = load && (!w_full || ack);
    w_pop   = ack && !w_empty;
    w_drop  = load && !w_push;
    w_op    = fifo_op_e'({w_pop, w_push});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_ovf    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case (w_op)
        OP_PUSH: r_occ <= r_occ + CW'(1);
        OP_POP:  r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_comb begin
    valid = !w_empty;
    full  = w_full;
    count = r_occ;
    ovf   = r_ovf;
    out   = w_empty ? '0 : r_mem[r_rd_ptr];
  end

endmodule

// File: rtl/request_register_bank.sv
// Multi-channel request holding stage: NUM_CH independent req_fifo channels
// presenting their oldest request and valid flag to the round-robin arbiter.
module request_register_bank
  import request_register_bank_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_CH = DEF_NUM_CH,
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] in,
  input  logic [NUM_CH-1:0]       ack,
  output logic [NUM_CH*WIDTH-1:0] out,
  output logic [NUM_CH-1:0]       valid,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH*CW-1:0]    count,
  output logic [NUM_CH-1:0]       ovf
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    req_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .load  (load[c]),
      .in    (in[c*WIDTH +: WIDTH]),
      .ack   (ack[c]),
      .out   (out[c*WIDTH +: WIDTH]),
      .valid (valid[c]),
      .full  (full[c]),
      .count (count[c*CW +: CW]),
      .ovf   (ovf[c])
    );
  end

endmodule

// File: doc/request_register_bank.md
# request_register_bank

Parametrised multi-channel request holding stage in front of the round-robin arbiter. It generalises the single-channel load/ack request register. It has NUM_CH independent channels, and each channel buffers up to DEPTH requests of WIDTH bits in FIFO order. Each channel presents its oldest request and a valid flag to the arbiter, and releases that request when the arbiter acknowledges it.

## Interface
Parameters:
- WIDTH, 4, payload bits per request
- DEPTH, 2, entries per channel (≥1, any integer, not restricted to powers of two)
- NUM_CH, 4, number of channels (≥1)
- CW, derived = clog2(DEPTH+1), occupancy counter width (not overridable)

Ports:
- clk  in  1  rising-edge clock; the block uses this single clock
- rst  in  1  reset, asynchronous, active-low
- load  in  NUM_CH  per-channel push strobe; captures the channel's slice of in
- in  in  NUM_CH*WIDTH  request payloads; channel c occupies bits [c*WIDTH +: WIDTH]
- ack  in  NUM_CH  per-channel release strobe from the arbiter; pops the head entry
- out  out  NUM_CH*WIDTH  head payload per channel, same slicing as in
- valid  out  NUM_CH  channel holds ≥1 entry
- full  out  NUM_CH  channel holds DEPTH entries
- count  out  NUM_CH*CW  per-channel occupancy, channel c at [c*CW +: CW]
- ovf  out  NUM_CH  sticky overflow flag; a load was dropped on that channel

## Operation
- Channels are fully independent. No cross-channel state exists.
- Each channel is a circular buffer with wr_ptr, rd_ptr and occ.
  - Pointers run 0..DEPTH-1 and wrap from DEPTH-1 to 0. No power-of-two masking is used.
- Push: load=1 and (occ<DEPTH or ack=1) → write in-slice at wr_ptr, then advance wr_ptr.
- Pop: ack=1 and occ>0 → advance rd_ptr.
- Occupancy update: occ += push − pop, evaluated from pre-edge occ.
- Boundary cases:
  - Empty with load and ack together: push only. ack is ignored and there is no fall-through. Next occ=1.
  - Full with load and ack together: both succeed. occ stays DEPTH and the new entry goes to the tail.
  - Full with load only: load is dropped, the buffer is unchanged, and ovf[c] is set. ovf clears only on reset.
  - Empty with ack only: no effect. This is not an error.
  - DEPTH=1: behaves as a single register. A simultaneous load and ack on a full channel replaces the entry.
- out[c] = entry at rd_ptr when occ>0, else all zeros.
- valid = (occ≠0) and full = (occ==DEPTH), both decoded from registered occ.
- Reset effects: occ, pointers, storage and ovf are cleared. All outputs are 0 (out=0, valid=0, full=0, count=0, ovf=0).

## Timing
- All state updates on the rising edge of clk. Reset acts immediately on assertion, independent of clk, and releases synchronously on the next edge after rst goes high.
- Outputs are glitch-free functions of registers only. There is no combinational path from load, ack or in to any output.
- Load latency is 1 cycle: load sampled at edge k → valid=1 and out=payload after edge k.
- Release latency is 1 cycle: ack sampled at edge k → out shows the next entry (or 0) after edge k.
- Sustained throughput: one push and one pop per channel per cycle.
- Reset asserted mid-operation discards all buffered entries. load and ack in the cycle of release are honoured normally.

## Structure
- A shared header holds a clog2 constant function and the default WIDTH/DEPTH/NUM_CH values. The arbiter uses the same values.
- One sub-module, req_fifo: a single channel with parameters WIDTH and DEPTH and ports clk, rst, load, in, ack, out, valid, full, count, ovf.
- The top instantiates NUM_CH copies via generate and only slices the buses.

## Test plan
- Reset: drive rst=0 mid-cycle with traffic → all outputs 0 immediately. Release, then load ch0 in=4'b1101 → out[3:0]=1101, valid[0]=1, count=1 one cycle later.
- FIFO order and wrap (DEPTH=2): load ch1 1010, 0111, then ack twice, then repeat three times → out sequence 1010, 0111, then 0000 with valid=0. Pointers wrap with no data corruption.
- Full/overflow: load ch2 1000, 0001, 0011 without ack → full[2]=1, count=2, ovf[2]=1. Head stays 1000 and 0011 is never output.
- Simultaneous events: on full ch3, load 1111 with ack → count stays 2 and head advances; 1111 appears after the remaining entry. On empty ch3, load 0101 with ack → count=1 and out=0101.
- Channel independence: random load/ack on all 4 channels for 1000 cycles against a per-channel queue model → out, valid, full, count and ovf match every cycle.
- DEPTH=1, NUM_CH=1 build: simultaneous load and ack on a full channel replaces the entry with the new payload. valid stays 1.
